// File: rtl/bus_snapshot_reader_if.sv
// OUTBUS/INBUS peripheral bus: a registered-read byte bus plus a single-cycle write strobe.
interface bus_snapshot_reader_if;
  logic [7:0] OUTBUS_ADDR;
  logic [7:0] OUTBUS_DATA;
  logic       OUTBUS_WE;
  logic [7:0] INBUS_ADDR;
  logic [7:0] INBUS_DATA;
  logic       INBUS_RE;

  modport master (
    output OUTBUS_ADDR, OUTBUS_DATA, OUTBUS_WE, INBUS_ADDR, INBUS_RE,
    input  INBUS_DATA
  );

  modport slave (
    input  OUTBUS_ADDR, OUTBUS_DATA, OUTBUS_WE, INBUS_ADDR, INBUS_RE,
    output INBUS_DATA
  );
endinterface

// File: rtl/bus_snapshot_reader.sv
// Bus initiator: optional control write, then NBYTES pipelined byte reads assembled
// MSB-first into a shadow word, published atomically with a one-cycle done strobe.
module bus_snapshot_reader #(
  parameter logic [7:0] DEVADDR = 8'h00,
  parameter int         NBYTES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cmd_en,
  input  logic [7:0]            cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   value,
  bus_snapshot_reader_if.master bus
);
  localparam int            VW   = 8*NBYTES;
  localparam int            IW   = 5;
  localparam logic [IW-1:0] LAST = IW'(NBYTES-1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic            cap_q, cap_d;
  logic [7:0]      waddr_q, waddr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      raddr_q, raddr_d;
  logic [VW-1:0]   shadow_q, shadow_d;
  logic [VW-1:0]   value_q, value_d;
  logic [VW+7:0]   shift_in;

  // Shifting left means the first byte read ends up in the MSB after NBYTES captures.
  assign shift_in = {shadow_q, bus.INBUS_DATA};

  // Next-state and next-output logic; every output is decided one cycle ahead so it can be registered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    we_d     = 1'b0;
    waddr_d  = 8'h00;
    wdata_d  = 8'h00;
    re_d     = 1'b0;
    raddr_d  = 8'h00;
    // Target registers the read, so data for a strobe arrives one cycle later.
    cap_d    = re_q;
    shadow_d = shadow_q;
    value_d  = value_q;
    if (cap_q) shadow_d = shift_in[VW-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = '0;
          if (cmd_en) begin
            state_d = WRITE;
            we_d    = 1'b1;
            waddr_d = DEVADDR;
            wdata_d = cmd_data;
          end else begin
            state_d = READ;
            re_d    = 1'b1;
            raddr_d = DEVADDR;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      WRITE: begin
        state_d = READ;
        idx_d   = '0;
        re_d    = 1'b1;
        raddr_d = DEVADDR;
      end
      READ: begin
        if (idx_q == LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          re_d    = 1'b1;
          raddr_d = DEVADDR + 8'(idx_d);
        end
      end
      DRAIN: begin
        // Final byte lands in shadow_d this cycle; publish the complete word at once.
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        value_d = shadow_d;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction and clears the published word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      cap_q    <= 1'b0;
      waddr_q  <= 8'h00;
      wdata_q  <= 8'h00;
      raddr_q  <= 8'h00;
      shadow_q <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      re_q     <= re_d;
      cap_q    <= cap_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign value           = value_q;
  assign bus.OUTBUS_WE   = we_q;
  assign bus.OUTBUS_ADDR = waddr_q;
  assign bus.OUTBUS_DATA = wdata_q;
  assign bus.INBUS_RE    = re_q;
  assign bus.INBUS_ADDR  = raddr_q;
endmodule

// File: tb/tb_bus_snapshot_reader.sv
// Directed bench: two readers (8 bytes at 0x10, 4 bytes at 0xFE) against registered byte targets.
module tb_bus_snapshot_reader;
  logic        clk = 1'b0;
  logic        reset, start, cmd_en;
  logic [7:0]  cmd_data;
  logic        busy_a, done_a, busy_b, done_b;
  logic [63:0] value_a;
  logic [31:0] value_b;
  logic [7:0]  xmask;
  logic [7:0]  rdata_a, rdata_b;
  int          n_chk = 0;
  int          n_err = 0;

  // Per-cycle traces, index = cycle number relative to the start cycle.
  logic        a_re[0:31], a_we[0:31], a_done[0:31], a_busy[0:31];
  logic [7:0]  a_raddr[0:31], a_waddr[0:31], a_wdata[0:31];
  logic [63:0] a_val[0:31];
  logic        b_re[0:31], b_done[0:31];
  logic [7:0]  b_raddr[0:31];
  logic [31:0] b_val[0:31];

  always #5 clk = ~clk;

  bus_snapshot_reader_if bus_a();
  bus_snapshot_reader_if bus_b();

  bus_snapshot_reader #(.DEVADDR(8'h10), .NBYTES(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .cmd_en(cmd_en), .cmd_data(cmd_data),
    .busy(busy_a), .done(done_a), .value(value_a), .bus(bus_a));

  bus_snapshot_reader #(.DEVADDR(8'hFE), .NBYTES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .cmd_en(cmd_en), .cmd_data(cmd_data),
    .busy(busy_b), .done(done_b), .value(value_b), .bus(bus_b));

  // Target A: 0x10..0x17 return 0x11..0x88, optionally XORed to make snapshots distinguishable.
  function automatic logic [7:0] tgt_a(input logic [7:0] addr);
    logic [7:0] base;
    base = 8'(addr - 8'h0F) * 8'h11;
    if (addr >= 8'h10 && addr <= 8'h17) return base ^ xmask;
    return 8'h00;
  endfunction

  always_ff @(posedge clk) rdata_a <= bus_a.INBUS_RE ? tgt_a(bus_a.INBUS_ADDR) : 8'h00;
  always_ff @(posedge clk) rdata_b <= bus_b.INBUS_RE ? (bus_b.INBUS_ADDR ^ 8'hA5) : 8'h00;
  assign bus_a.INBUS_DATA = rdata_a;
  assign bus_b.INBUS_DATA = rdata_b;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Start in cycle 0, hold start through start_last, extra pulses at pa/pb,
  // switch target mask to 0xFF at mask_at, pulse reset low in cycle abort_at.
  task automatic run(input int ncyc, input int start_last, input int pa, input int pb,
                     input int mask_at, input int abort_at);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      a_re[c] = bus_a.INBUS_RE;     a_raddr[c] = bus_a.INBUS_ADDR;
      a_we[c] = bus_a.OUTBUS_WE;    a_waddr[c] = bus_a.OUTBUS_ADDR;
      a_wdata[c] = bus_a.OUTBUS_DATA;
      a_done[c] = done_a;  a_busy[c] = busy_a;  a_val[c] = value_a;
      b_re[c] = bus_b.INBUS_RE;  b_raddr[c] = bus_b.INBUS_ADDR;
      b_done[c] = done_b;  b_val[c] = value_b;
      chk("we_re_excl", 64'(bus_a.OUTBUS_WE & bus_a.INBUS_RE), 64'd0);
      start = (c <= start_last) || (c == pa) || (c == pb);
      if (c == mask_at) xmask = 8'hFF;
      if (c == abort_at) reset = 1'b0;
      if (c == abort_at + 1) reset = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic check_plain(input string t, input logic [63:0] exp);
    for (int c = 1; c <= 14; c++) begin
      chk({t, "_re"},    64'(a_re[c]),    64'(c <= 8));
      chk({t, "_raddr"}, 64'(a_raddr[c]), (c <= 8) ? 64'(8'h10 + 8'(c - 1)) : 64'd0);
      chk({t, "_done"},  64'(a_done[c]),  64'(c == 10));
      chk({t, "_busy"},  64'(a_busy[c]),  64'(c <= 9));
      chk({t, "_we"},    64'(a_we[c]),    64'd0);
    end
    chk({t, "_val"}, a_val[10], exp);
  endtask

  initial begin
    logic [7:0] b_addr_exp [0:3];
    int n_done, n_re;
    b_addr_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    reset = 1'b0; start = 1'b1; cmd_en = 1'b0; cmd_data = 8'h00; xmask = 8'h00;

    // Reset held with start asserted: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_val_a", value_a, 64'd0);
      chk("rst_ctl_a", 64'({busy_a, done_a, bus_a.OUTBUS_WE, bus_a.OUTBUS_ADDR, bus_a.OUTBUS_DATA,
                            bus_a.INBUS_RE, bus_a.INBUS_ADDR}), 64'd0);
      chk("rst_b", 64'({busy_b, done_b, value_b, bus_b.INBUS_RE, bus_b.OUTBUS_WE}), 64'd0);
    end
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({busy_a, bus_a.INBUS_RE, bus_a.OUTBUS_WE, busy_b, bus_b.INBUS_RE}), 64'd0);
    end

    // Plain read on A; wrap-around read on B in the same run.
    run(14, 0, -1, -1, -1, -1);
    check_plain("plain", 64'h1122334455667788);
    for (int c = 1; c <= 14; c++) begin
      chk("wrap_re",    64'(b_re[c]),    64'(c <= 4));
      chk("wrap_raddr", 64'(b_raddr[c]), (c <= 4) ? 64'(b_addr_exp[c-1]) : 64'd0);
      chk("wrap_done",  64'(b_done[c]),  64'(c == 6));
    end
    chk("wrap_val", 64'(b_val[6]), 64'h5B5AA5A4);

    // Control write then read.
    cmd_en = 1'b1; cmd_data = 8'h03; xmask = 8'h0F;
    run(14, 0, -1, -1, -1, -1);
    cmd_en = 1'b0; cmd_data = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      chk("cmd_we",    64'(a_we[c]),    64'(c == 1));
      chk("cmd_waddr", 64'(a_waddr[c]), (c == 1) ? 64'h10 : 64'd0);
      chk("cmd_wdata", 64'(a_wdata[c]), (c == 1) ? 64'h03 : 64'd0);
      chk("cmd_re",    64'(a_re[c]),    64'(c >= 2 && c <= 9));
      chk("cmd_raddr", 64'(a_raddr[c]), (c >= 2 && c <= 9) ? 64'(8'h10 + 8'(c - 2)) : 64'd0);
      chk("cmd_done",  64'(a_done[c]),  64'(c == 11));
    end
    chk("cmd_val_hold", a_val[10], 64'h1122334455667788);
    chk("cmd_val",      a_val[11], 64'h1E2D3C4B5A697887);

    // Back-to-back: start held high through the first done cycle.
    xmask = 8'h00;
    run(24, 10, -1, -1, 10, -1);
    for (int c = 1; c <= 24; c++) begin
      chk("b2b_re",   64'(a_re[c]),   64'((c >= 1 && c <= 8) || (c >= 11 && c <= 18)));
      chk("b2b_done", 64'(a_done[c]), 64'(c == 10 || c == 20));
      chk("b2b_busy", 64'(a_busy[c]), 64'((c >= 1 && c <= 9) || (c >= 11 && c <= 19)));
    end
    chk("b2b_val9",  a_val[9],  64'h1E2D3C4B5A697887);
    chk("b2b_val10", a_val[10], 64'h1122334455667788);
    chk("b2b_val19", a_val[19], 64'h1122334455667788);
    chk("b2b_val20", a_val[20], 64'hEEDDCCBBAA998877);

    // Start pulses while busy are dropped.
    xmask = 8'h00;
    run(16, 0, 3, 7, -1, -1);
    n_done = 0; n_re = 0;
    for (int c = 1; c <= 16; c++) begin
      n_done += int'(a_done[c]);
      n_re   += int'(a_re[c]);
    end
    chk("ign_done_cnt", 64'(n_done), 64'd1);
    chk("ign_re_cnt",   64'(n_re),   64'd8);
    chk("ign_done10",   64'(a_done[10]), 64'd1);
    chk("ign_val",      a_val[10], 64'h1122334455667788);

    // Abort mid-read, then a clean transaction.
    run(16, 0, -1, -1, -1, 5);
    chk("abort_re5",  64'(a_re[5]),  64'd1);
    chk("abort_re6",  64'(a_re[6]),  64'd0);
    chk("abort_val6", a_val[6],      64'd0);
    chk("abort_busy6", 64'(a_busy[6]), 64'd0);
    n_done = 0; n_re = 0;
    for (int c = 6; c <= 16; c++) begin
      n_done += int'(a_done[c]);
      n_re   += int'(a_re[c]);
    end
    chk("abort_quiet", 64'(n_done + n_re), 64'd0);
    xmask = 8'h00;
    run(14, 0, -1, -1, -1, -1);
    check_plain("after_abort", 64'h1122334455667788);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
